// File: rtl/wb_bram_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone BRAM arbiter: FSM state
// encoding, grant encodings, last-served codes and a state-to-grant helper.
// The state encoding equals the one-hot grant, so gnt_o is the state register.
package wb_bram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_GNT0 = 2'b01,
        ST_GNT1 = 2'b10
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    // Identity of the master that most recently released the bus
    localparam logic LAST_M0 = 1'b0;
    localparam logic LAST_M1 = 1'b1;

    function automatic logic [1:0] state_to_gnt(input arb_state_e st);
        logic [1:0] g;
        case (st)
            ST_GNT0: g = GNT_M0;
            ST_GNT1: g = GNT_M1;
            default: g = GNT_NONE;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/wb_bram_arb_rr.sv
// Round-robin next-grant logic for the Wishbone BRAM arbiter. Pure
// combinational: from both cyc requests, the current state and the
// last-served master it produces the next state and next last-served.
// A grant is only given up when its master drops cyc at a clock edge.
module wb_bram_arb_rr
    import wb_bram_arbiter_pkg::*;
(
    input  logic       cyc0,
    input  logic       cyc1,
    input  arb_state_e state,
    input  logic       last,
    output arb_state_e next_state,
    output logic       next_last
);

    // Next grant: ties in IDLE go to the master not served last; handover is direct
    always_comb begin
        next_state = state;
        next_last  = last;
        case (state)
            ST_IDLE: begin
                if (cyc0 && cyc1) begin
                    next_state = (last == LAST_M1) ? ST_GNT0 : ST_GNT1;
                end else if (cyc0) begin
                    next_state = ST_GNT0;
                end else if (cyc1) begin
                    next_state = ST_GNT1;
                end
            end
            ST_GNT0: begin
                if (!cyc0) begin
                    next_last  = LAST_M0;
                    next_state = cyc1 ? ST_GNT1 : ST_IDLE;
                end
            end
            ST_GNT1: begin
                if (!cyc1) begin
                    next_last  = LAST_M1;
                    next_state = cyc0 ? ST_GNT0 : ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/wb_bram_arbiter.sv
// Two-master, one-slave Wishbone B3 classic arbiter in front of the BRAM port.
// m0 is the CPU core, m1 the DMA/debug master. The grant is registered, held
// for the whole CYC and rotated round-robin on release.
// Handshake: a transfer completes at the rising edge where the granted master
// has cyc&stb high and the slave returns ack; ack/err/dat go only to the
// granted master, the other sees zeros and simply waits with its cyc high.
// Optional macro WB_ARB_TIMEOUT_EN adds a slave-ack watchdog that answers a
// stalled transfer with a one-cycle err after TIMEOUT wait cycles.
module wb_bram_arbiter
    import wb_bram_arbiter_pkg::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    output logic [1:0]      gnt_o,
    output logic [1:0]      dbg_state
);

    arb_state_e state;
    arb_state_e next_state;
    logic       last;
    logic       next_last;
    logic       sel0;
    logic       sel1;
    logic       timeout_hit;

    wb_bram_arb_rr u_rr (
        .cyc0       (m0_cyc_i),
        .cyc1       (m1_cyc_i),
        .state      (state),
        .last       (last),
        .next_state (next_state),
        .next_last  (next_last)
    );

    // Grant state and last-served master; reset leaves m0 winning the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            last  <= LAST_M1;
        end else begin
            state <= next_state;
            last  <= next_last;
        end
    end

    assign sel0      = (state == ST_GNT0);
    assign sel1      = (state == ST_GNT1);
    assign gnt_o     = state_to_gnt(state);
    assign dbg_state = state;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW_RAW = $clog2(TIMEOUT + 1);
    localparam int CW     = (CW_RAW < 8) ? 8 : CW_RAW;

    logic [CW-1:0] wait_cnt;

    assign timeout_hit = (wait_cnt == CW'(TIMEOUT));

    // Counts cycles a strobed transfer waits for ack; restarts on any progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (timeout_hit || (next_state != state) || !s_stb_o || s_ack_i) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    assign m0_err_o = sel0 & timeout_hit;
    assign m1_err_o = sel1 & timeout_hit;
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = TIMEOUT;
    assign timeout_hit    = 1'b0;
    assign m0_err_o       = 1'b0;
    assign m1_err_o       = 1'b0;
`endif

    // Slave side follows the granted master; idle and timeout cycles present nothing
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        if (sel0) begin
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_stb_i;
            s_we_o  = m0_we_i;
            s_sel_o = m0_sel_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
        end else if (sel1) begin
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_stb_i;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
        end
        if (timeout_hit) begin
            s_cyc_o = 1'b0;
            s_stb_o = 1'b0;
        end
    end

    assign m0_ack_o = sel0 & s_ack_i & ~timeout_hit;
    assign m1_ack_o = sel1 & s_ack_i & ~timeout_hit;
    assign m0_dat_o = sel0 ? s_dat_i : '0;
    assign m1_dat_o = sel1 ? s_dat_i : '0;

endmodule
